alu_operand_sequencer: RTL and testbench

- Sequencer between the DE1-SoC board I/O (KEY/SW/HEX) and a WIDTH-bit ALU.
- Operands are built from 4-bit switch entries, loaded nibble-by-nibble into two shift registers.
- An operation is launched on a run keypress; the result and Z/V/C/N flags are captured.
- The result is shown as 16-bit display pages that the user can step through.
- Replaces the single-nibble combinational loading path in the lab top level with a debounced, registered FSM.

---
 rtl/alu_operand_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: sequencer between the DE1-SoC KEY/SW/HEX I/O and a
// WIDTH-bit ALU. Operand nibbles are shifted into bus_a/bus_b on debounced
// enter presses. A debounced run press latches the opcode and pulses
// alu_start. The result and flags are captured ALU_LAT cycles later and then
// shown as 16-bit pages.
//
// Ports:
//   clock, reset_n         system clock, async active-low reset
//   enter_n, run_n         raw active-low keys (asynchronous to clock)
//   sw_data, sw_sel        nibble to load / 00=A, 01=B, 1x=page select
//   sw_ctrl                opcode, sampled on run
//   alu_result, alu_flags  ALU outputs ({z,v,c,n})
//   bus_a, bus_b, control  operand and opcode registers driving the ALU
//   alu_start              one-cycle launch pulse
//   disp_word, disp_en     selected 16-bit result page and its valid flag
//   page, flags, busy      page index, captured flags, high while executing

// Key conditioner: 2-flop synchroniser followed by a debounce counter.
// The counter only runs while the synchronised level differs from the
// accepted level. press_ev fires in the cycle in which a press is accepted.
module alu_operand_sequencer_key #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic key_n,
    output logic press_ev
);
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic [1:0]       sync_q;
    logic             deb_q;
    logic [CNT_W-1:0] cnt_q;
    logic             differs;
    logic             accept;

    assign differs  = sync_q[1] != deb_q;
    assign accept   = differs && (cnt_q == CNT_W'(DEB_CYCLES - 1));
    // Only presses (accepted high-to-low) generate events; releases are silent.
    assign press_ev = accept && !sync_q[1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
            deb_q  <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], key_n};
            if (!differs) begin
                cnt_q <= '0;
            end else if (accept) begin
                deb_q <= sync_q[1];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

module alu_operand_sequencer #(
    parameter int WIDTH      = 32,
    parameter int CTRL_W     = 3,
    parameter int ALU_LAT    = 1,
    parameter int DEB_CYCLES = 16,
    localparam int NPG       = WIDTH / 16,
    localparam int PG_W      = (NPG > 1) ? $clog2(NPG) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enter_n,
    input  logic              run_n,
    input  logic [3:0]        sw_data,
    input  logic [1:0]        sw_sel,
    input  logic [CTRL_W-1:0] sw_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic [3:0]        alu_flags,
    output logic [WIDTH-1:0]  bus_a,
    output logic [WIDTH-1:0]  bus_b,
    output logic [CTRL_W-1:0] control,
    output logic              alu_start,
    output logic [15:0]       disp_word,
    output logic              disp_en,
    output logic [PG_W-1:0]   page,
    output logic [3:0]        flags,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, EXEC, SHOW} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [3:0]          flg_q, flg_d, lat_q, lat_d;
    logic [PG_W-1:0]     pg_q, pg_d;
    logic                enter_ev, run_ev;
    logic                do_launch, do_shift, do_page;
    logic [NPG-1:0][15:0] pages;

    alu_operand_sequencer_key #(.DEB_CYCLES(DEB_CYCLES)) u_enter (
        .clock(clock), .reset_n(reset_n), .key_n(enter_n), .press_ev(enter_ev)
    );
    alu_operand_sequencer_key #(.DEB_CYCLES(DEB_CYCLES)) u_run (
        .clock(clock), .reset_n(reset_n), .key_n(run_n), .press_ev(run_ev)
    );

    // Events are dropped while executing. Run wins over a same-cycle enter.
    assign do_launch = run_ev && (state_q != EXEC);
    assign do_shift  = enter_ev && !run_ev && !sw_sel[1] && (state_q != EXEC);
    assign do_page   = enter_ev && !run_ev && sw_sel[1] && (state_q == SHOW);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        ctrl_d    = ctrl_q;
        flg_d     = flg_q;
        lat_d     = lat_q;
        pg_d      = pg_q;
        alu_start = 1'b0;

        if (do_launch) begin
            ctrl_d    = sw_ctrl;
            alu_start = 1'b1;
            lat_d     = 4'(ALU_LAT);
            state_d   = EXEC;
        end else if (do_shift) begin
            if (sw_sel[0]) b_d = {b_q[WIDTH-5:0], sw_data};
            else           a_d = {a_q[WIDTH-5:0], sw_data};
            state_d = IDLE;
        end else if (do_page) begin
            // With a single page this wraps straight back to 0.
            pg_d = (pg_q == PG_W'(NPG - 1)) ? '0 : pg_q + 1'b1;
        end

        if (state_q == EXEC) begin
            // lat_q reaches 1 in the cycle ALU_LAT after the alu_start cycle.
            if (lat_q == 4'd1) begin
                res_d   = alu_result;
                flg_d   = alu_flags;
                pg_d    = '0;
                state_d = SHOW;
            end else begin
                lat_d = lat_q - 1'b1;
            end
        end else if (state_q != IDLE && state_q != SHOW) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ctrl_q  <= '0;
            flg_q   <= '0;
            lat_q   <= '0;
            pg_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ctrl_q  <= ctrl_d;
            flg_q   <= flg_d;
            lat_q   <= lat_d;
            pg_q    <= pg_d;
        end
    end

    assign pages     = res_q;
    assign bus_a     = a_q;
    assign bus_b     = b_q;
    assign control   = ctrl_q;
    assign flags     = flg_q;
    assign page      = pg_q;
    assign busy      = (state_q == EXEC);
    assign disp_en   = (state_q == SHOW);
    assign disp_word = disp_en ? pages[pg_q] : 16'h0000;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;
    localparam int W   = 32;
    localparam int CW  = 3;
    localparam int LAT = 3;
    localparam int D   = 4;

    logic          clock = 1'b0;
    logic          reset_n, enter_n, run_n;
    logic [3:0]    sw_data;
    logic [1:0]    sw_sel;
    logic [CW-1:0] sw_ctrl;
    logic [W-1:0]  alu_result, bus_a, bus_b;
    logic [3:0]    alu_flags, flags;
    logic [CW-1:0] control;
    logic          alu_start, disp_en, busy;
    logic [15:0]   disp_word;
    logic [0:0]    page;

    logic [W-1:0]  tb_res;
    logic [3:0]    tb_flg;
    logic [LAT:1]  sp;
    int            n_run = 0, n_fail = 0;
    int            n_start = 0, n_busy = 0;

    always #5 clock = ~clock;

    alu_operand_sequencer #(.WIDTH(W), .CTRL_W(CW), .ALU_LAT(LAT), .DEB_CYCLES(D)) dut (
        .clock(clock), .reset_n(reset_n), .enter_n(enter_n), .run_n(run_n),
        .sw_data(sw_data), .sw_sel(sw_sel), .sw_ctrl(sw_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .bus_a(bus_a), .bus_b(bus_b), .control(control), .alu_start(alu_start),
        .disp_word(disp_word), .disp_en(disp_en), .page(page), .flags(flags),
        .busy(busy)
    );

    // ALU model: the result is only valid exactly LAT cycles after alu_start;
    // at any other time it presents all-ones so a mistimed capture shows up.
    always @(posedge clock or negedge reset_n)
        if (!reset_n) sp <= '0;
        else          sp <= {sp[LAT-1:1], alu_start};
    assign alu_result = sp[LAT] ? tb_res : '1;
    assign alu_flags  = sp[LAT] ? tb_flg : 4'hF;

    always @(negedge clock) begin
        if (alu_start) n_start++;
        if (busy)      n_busy++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic press_enter(input logic [1:0] sel, input logic [3:0] d);
        @(negedge clock);
        sw_sel = sel; sw_data = d; enter_n = 1'b0;
        repeat (D + 4) @(negedge clock);
        enter_n = 1'b1;
        repeat (D + 4) @(negedge clock);
    endtask

    typedef struct {
        logic [1:0]   sel;
        logic [3:0]   d;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
    } vec_t;
    vec_t tv[12];

    logic [W-1:0] pa, pb;
    logic [15:0]  pw[3];
    logic         pp[3];
    int           s0, b0;

    initial begin
        tv[0]  = '{2'd0, 4'h1, 32'h0000_0001, 32'h0};
        tv[1]  = '{2'd0, 4'h2, 32'h0000_0012, 32'h0};
        tv[2]  = '{2'd0, 4'h3, 32'h0000_0123, 32'h0};
        tv[3]  = '{2'd0, 4'h4, 32'h0000_1234, 32'h0};
        tv[4]  = '{2'd0, 4'h5, 32'h0001_2345, 32'h0};
        tv[5]  = '{2'd0, 4'h6, 32'h0012_3456, 32'h0};
        tv[6]  = '{2'd0, 4'h7, 32'h0123_4567, 32'h0};
        tv[7]  = '{2'd0, 4'h8, 32'h1234_5678, 32'h0};
        tv[8]  = '{2'd1, 4'h3, 32'h1234_5678, 32'h3};
        tv[9]  = '{2'd2, 4'h9, 32'h1234_5678, 32'h3};
        tv[10] = '{2'd3, 4'hF, 32'h1234_5678, 32'h3};
        tv[11] = '{2'd0, 4'hA, 32'h2345_678A, 32'h3};

        reset_n = 1'b0; enter_n = 1'b1; run_n = 1'b1;
        sw_data = '0; sw_sel = '0; sw_ctrl = '0;
        tb_res = '0; tb_flg = '0;
        #3;
        chk("rst_bus_a", bus_a, 0);
        chk("rst_bus_b", bus_b, 0);
        chk("rst_outs", {control, alu_start, disp_word, disp_en, page, flags, busy}, 0);
        @(negedge clock); reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // Operand loading: value held until exactly 2+D edges after the raw press.
        pa = '0; pb = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            sw_sel = tv[i].sel; sw_data = tv[i].d; enter_n = 1'b0;
            repeat (1 + D) @(posedge clock);
            #1;
            chk("load_pre_a", bus_a, pa);
            chk("load_pre_b", bus_b, pb);
            @(posedge clock);
            #1;
            chk("load_a", bus_a, tv[i].ea);
            chk("load_b", bus_b, tv[i].eb);
            chk("load_idle_disp", disp_en, 0);
            @(negedge clock); enter_n = 1'b1;
            repeat (D + 4) @(negedge clock);
            pa = tv[i].ea; pb = tv[i].eb;
        end

        // Glitch of D-1 cycles is rejected; a long hold shifts exactly once.
        @(negedge clock); sw_sel = 2'd0; sw_data = 4'hB; enter_n = 1'b0;
        repeat (D - 1) @(negedge clock);
        enter_n = 1'b1;
        repeat (D + 6) @(negedge clock);
        chk("glitch_a", bus_a, 32'h2345_678A);
        enter_n = 1'b0;
        repeat (1000) @(negedge clock);
        enter_n = 1'b1;
        repeat (D + 4) @(negedge clock);
        chk("hold_a", bus_a, 32'h3456_78AB);

        // bus_a = 5 via eight nibbles; bus_b is already 3.
        for (int i = 0; i < 8; i++) press_enter(2'd0, (i == 7) ? 4'h5 : 4'h0);
        chk("set_a", bus_a, 32'h5);
        chk("set_b", bus_b, 32'h3);

        // Launch 5 + 3.
        tb_res = 32'h8; tb_flg = 4'b0000; sw_ctrl = 3'b010;
        s0 = n_start; b0 = n_busy;
        @(negedge clock); run_n = 1'b0;
        repeat (2 + D + LAT + 4) @(negedge clock);
        chk("exec_starts", n_start - s0, 1);
        chk("exec_busy", n_busy - b0, LAT);
        chk("exec_word", disp_word, 16'h0008);
        chk("exec_en", disp_en, 1);
        chk("exec_flags", flags, 0);
        chk("exec_ctrl", control, 3'b010);
        chk("exec_busy_end", busy, 0);
        run_n = 1'b1;
        repeat (D + 4) @(negedge clock);

        // Relaunch from SHOW, then page through the result.
        tb_res = 32'hDEAD_BEEF; tb_flg = 4'b1010; sw_ctrl = 3'b001;
        s0 = n_start;
        @(negedge clock); run_n = 1'b0;
        repeat (2 + D + LAT + 4) @(negedge clock);
        run_n = 1'b1;
        repeat (D + 4) @(negedge clock);
        chk("relaunch_starts", n_start - s0, 1);
        chk("pg0_word", disp_word, 16'hBEEF);
        chk("pg0_page", page, 0);
        chk("pg_flags", flags, 4'b1010);
        chk("pg_ctrl", control, 3'b001);
        pw[0] = 16'hDEAD; pw[1] = 16'hBEEF; pw[2] = 16'hDEAD;
        pp[0] = 1'b1;     pp[1] = 1'b0;     pp[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            press_enter(2'd2, 4'h0);
            chk("pg_word", disp_word, pw[i]);
            chk("pg_page", page, pp[i]);
        end
        chk("pg_keep_a", bus_a, 32'h5);

        // Enter lands during EXEC while run is held: dropped, single launch.
        tb_res = 32'h0000_1234; tb_flg = 4'b0001;
        s0 = n_start;
        @(negedge clock); sw_sel = 2'd0; sw_data = 4'h9; run_n = 1'b0;
        @(negedge clock); enter_n = 1'b0;
        repeat (D + LAT + 8) @(negedge clock);
        chk("exec_ign_a", bus_a, 32'h5);
        chk("exec_ign_starts", n_start - s0, 1);
        chk("exec_ign_word", disp_word, 16'h1234);
        chk("exec_ign_page", page, 0);
        run_n = 1'b1; enter_n = 1'b1;
        repeat (D + 4) @(negedge clock);

        // Leave SHOW via an operand load, then simultaneous events in IDLE.
        press_enter(2'd0, 4'h6);
        chk("show_load_a", bus_a, 32'h56);
        chk("show_load_en", disp_en, 0);
        chk("show_keep_flags", flags, 4'b0001);
        s0 = n_start;
        @(negedge clock); sw_data = 4'h7; run_n = 1'b0; enter_n = 1'b0;
        repeat (D + LAT + 6) @(negedge clock);
        chk("simul_a", bus_a, 32'h56);
        chk("simul_starts", n_start - s0, 1);
        chk("simul_en", disp_en, 1);
        run_n = 1'b1; enter_n = 1'b1;
        repeat (D + 4) @(negedge clock);

        // Reset in the middle of EXEC.
        @(negedge clock); run_n = 1'b0;
        repeat (2 + D) @(negedge clock);
        chk("mid_busy", busy, 1);
        #2; reset_n = 1'b0; run_n = 1'b1;
        #1;
        chk("mid_rst_a", bus_a, 0);
        chk("mid_rst_b", bus_b, 0);
        chk("mid_rst_outs", {control, alu_start, disp_word, disp_en, page, flags, busy}, 0);
        @(negedge clock); reset_n = 1'b1;
        repeat (D + 4) @(negedge clock);
        chk("post_rst_en", disp_en, 0);
        chk("post_rst_busy", busy, 0);
        press_enter(2'd1, 4'hC);
        chk("post_rst_load_b", bus_b, 32'hC);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
